lspc_mode_timer: RTL and testbench

- LSPC control-register block. It owns the REG_LSPCMODE, TIMERHIGH, TIMERLOW and IRQACK CPU registers.
- It configures the auto-animation counter through AA_SPEED and AA_DISABLE, and folds AA_COUNT and the raster line into the LSPCMODE readback.
- It runs the 32-bit pixel-rate raster timer and holds the three LSPC interrupt flags (reset, timer, vblank) for the 68k interrupt logic.

---
 rtl/lspc_pkg.sv | 41 ++++
 rtl/lspc_timer_counter.sv | 51 +++++
 rtl/lspc_mode_timer.sv | 117 +++++++++++
 tb/tb_lspc_mode_timer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lspc_pkg.sv
// LSPC register map, LSPCMODE bit layout and IRQ flag indices.
package lspc_pkg;

  localparam logic [2:0] LSPC_VRAMRW = 3'd1;
  localparam logic [2:0] LSPC_MODE   = 3'd3;
  localparam logic [2:0] LSPC_TIMERH = 3'd4;
  localparam logic [2:0] LSPC_TIMERL = 3'd5;
  localparam logic [2:0] LSPC_IRQACK = 3'd6;

  localparam int MODE_AA_SPEED_LSB = 8;
  localparam int MODE_LOAD_ZERO    = 7;
  localparam int MODE_LOAD_VBL     = 6;
  localparam int MODE_LOAD_WR      = 5;
  localparam int MODE_TM_EN        = 4;
  localparam int MODE_AA_DISABLE   = 3;

  localparam int IRQ_VBL   = 0;
  localparam int IRQ_TIMER = 1;
  localparam int IRQ_RESET = 2;

  localparam logic [2:0] IRQ_RST_VAL = 3'b100;

  typedef struct packed {
    logic load_zero;
    logic load_vbl;
    logic load_wr;
    logic en;
  } tm_mode_t;

  function automatic tm_mode_t mode_decode(
    input logic [15:0] d
  );
    tm_mode_t m;
    m.load_zero = d[MODE_LOAD_ZERO];
    m.load_vbl  = d[MODE_LOAD_VBL];
    m.load_wr   = d[MODE_LOAD_WR];
    m.en        = d[MODE_TM_EN];
    return m;
  endfunction

endpackage

// File: rtl/lspc_timer_counter.sv
// Raster timer down-counter with load priority and zero detect.
module lspc_timer_counter
  import lspc_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixel_ce,
  input  logic               vbl_start,
  input  logic               load_wr,
  input  logic               load_vbl,
  input  logic               load_zero,
  input  logic [TIMER_W-1:0] load_val,
  input  logic [TIMER_W-1:0] reload,
  output logic               zero_evt
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;
  logic               is_zero;

  assign is_zero  = (cnt_q == '0);
  // zero event comes from the stored count, so it fires even when a load
  // overrides the decrement in the same cycle
  assign zero_evt = pixel_ce & is_zero;

  always_comb begin
    cnt_d = cnt_q;
    if (load_wr) begin
      cnt_d = load_val;
    end else if (vbl_start && load_vbl) begin
      cnt_d = reload;
    end else if (pixel_ce) begin
      if (is_zero) begin
        cnt_d = load_zero ? reload : '1;
      end else begin
        cnt_d = cnt_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lspc_mode_timer.sv
// LSPC control registers: LSPCMODE, raster timer reload and IRQ flags.
module lspc_mode_timer
  import lspc_pkg::*;
#(
  parameter int TIMER_W = 32,
  parameter int LINE_W  = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PIXEL_CE,
  input  logic              VBLANK_START,
  input  logic              WR_EN,
  input  logic [2:0]        ADDR,
  input  logic [15:0]       WR_DATA,
  input  logic [LINE_W-1:0] RASTER_LINE,
  input  logic              PAL_MODE,
  input  logic [2:0]        AA_COUNT,
  output logic [15:0]       RD_DATA,
  output logic [7:0]        AA_SPEED,
  output logic              AA_DISABLE,
  output logic [2:0]        IRQ_FLAGS
);

  logic [7:0]         aa_speed_q, aa_speed_d;
  logic               aa_dis_q, aa_dis_d;
  tm_mode_t           mode_q, mode_d;
  logic [TIMER_W-1:0] reload_q, reload_d;
  logic [2:0]         irq_q, irq_d;

  logic               wr_mode, wr_th, wr_tl, wr_ack;
  logic               zero_evt;
  logic [TIMER_W-1:0] load_val;
  logic [2:0]         irq_set, irq_clr;

  always_comb begin
    wr_mode = 1'b0;
    wr_th   = 1'b0;
    wr_tl   = 1'b0;
    wr_ack  = 1'b0;
    if (WR_EN) begin
      unique case (ADDR)
        LSPC_MODE:   wr_mode = 1'b1;
        LSPC_TIMERH: wr_th   = 1'b1;
        LSPC_TIMERL: wr_tl   = 1'b1;
        LSPC_IRQACK: wr_ack  = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    aa_speed_d = aa_speed_q;
    aa_dis_d   = aa_dis_q;
    mode_d     = mode_q;
    reload_d   = reload_q;
    if (wr_mode) begin
      aa_speed_d = WR_DATA[MODE_AA_SPEED_LSB+:8];
      aa_dis_d   = WR_DATA[MODE_AA_DISABLE];
      mode_d     = mode_decode(WR_DATA);
    end
    if (wr_th) begin
      reload_d[TIMER_W-1:16] = WR_DATA;
    end
    if (wr_tl) begin
      reload_d[15:0] = WR_DATA;
    end
  end

  // TIMERLOW load uses the new low half with the already-held high half
  assign load_val = {reload_q[TIMER_W-1:16], WR_DATA};

  lspc_timer_counter #(
    .TIMER_W (TIMER_W)
  ) u_counter (
    .clk       (CLK),
    .rst       (RESET),
    .pixel_ce  (PIXEL_CE),
    .vbl_start (VBLANK_START),
    .load_wr   (wr_tl & mode_q.load_wr),
    .load_vbl  (mode_q.load_vbl),
    .load_zero (mode_q.load_zero),
    .load_val  (load_val),
    .reload    (reload_q),
    .zero_evt  (zero_evt)
  );

  always_comb begin
    irq_set            = '0;
    irq_set[IRQ_TIMER] = zero_evt & mode_q.en;
    irq_set[IRQ_VBL]   = VBLANK_START;
    irq_clr            = wr_ack ? WR_DATA[2:0] : 3'b000;
    // a set in the same cycle beats the acknowledge
    irq_d              = (irq_q & ~irq_clr) | irq_set;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      aa_speed_q <= '0;
      aa_dis_q   <= 1'b0;
      mode_q     <= '0;
      reload_q   <= '0;
      irq_q      <= IRQ_RST_VAL;
    end else begin
      aa_speed_q <= aa_speed_d;
      aa_dis_q   <= aa_dis_d;
      mode_q     <= mode_d;
      reload_q   <= reload_d;
      irq_q      <= irq_d;
    end
  end

  assign RD_DATA    = {RASTER_LINE[8:0], 3'b000, PAL_MODE, AA_COUNT};
  assign AA_SPEED   = aa_speed_q;
  assign AA_DISABLE = aa_dis_q;
  assign IRQ_FLAGS  = irq_q;

endmodule

// File: tb/tb_lspc_mode_timer.sv
// Directed scoreboard bench for lspc_mode_timer.
module tb_lspc_mode_timer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PIXEL_CE;
  logic        VBLANK_START;
  logic        WR_EN;
  logic [2:0]  ADDR;
  logic [15:0] WR_DATA;
  logic [8:0]  RASTER_LINE;
  logic        PAL_MODE;
  logic [2:0]  AA_COUNT;
  logic [15:0] RD_DATA;
  logic [7:0]  AA_SPEED;
  logic        AA_DISABLE;
  logic [2:0]  IRQ_FLAGS;

  lspc_mode_timer #(.TIMER_W(32), .LINE_W(9)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PIXEL_CE     (PIXEL_CE),
    .VBLANK_START (VBLANK_START),
    .WR_EN        (WR_EN),
    .ADDR         (ADDR),
    .WR_DATA      (WR_DATA),
    .RASTER_LINE  (RASTER_LINE),
    .PAL_MODE     (PAL_MODE),
    .AA_COUNT     (AA_COUNT),
    .RD_DATA      (RD_DATA),
    .AA_SPEED     (AA_SPEED),
    .AA_DISABLE   (AA_DISABLE),
    .IRQ_FLAGS    (IRQ_FLAGS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam logic [2:0] A_MODE = 3'd3;
  localparam logic [2:0] A_TH   = 3'd4;
  localparam logic [2:0] A_TL   = 3'd5;
  localparam logic [2:0] A_ACK  = 3'd6;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    WR_EN        = 1'b0;
    PIXEL_CE     = 1'b0;
    VBLANK_START = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    WR_EN   = 1'b1;
    ADDR    = a;
    WR_DATA = d;
    tick();
  endtask

  task automatic pix(input int n);
    for (int i = 0; i < n; i++) begin
      PIXEL_CE = 1'b1;
      tick();
    end
  endtask

  function automatic logic [31:0] cnt();
    return dut.u_counter.cnt_q;
  endfunction

  initial begin
    RESET = 1'b1;
    PIXEL_CE = 0; VBLANK_START = 0; WR_EN = 0;
    ADDR = 0; WR_DATA = 0;
    RASTER_LINE = 0; PAL_MODE = 0; AA_COUNT = 0;
    repeat (2) @(posedge CLK);
    #1;
    expect_v("rst_flags_in_reset", 32'h4);
    check(IRQ_FLAGS);
    RESET = 1'b0;
    tick();
    expect_v("rst_flags", 32'h4);        check(IRQ_FLAGS);
    expect_v("rst_aa_speed", 32'h0);     check(AA_SPEED);
    expect_v("rst_aa_dis", 32'h0);       check(AA_DISABLE);
    expect_v("rst_cnt", 32'h0);          check(cnt());

    wr(A_ACK, 16'h0004);
    expect_v("ack_reset", 32'h0);        check(IRQ_FLAGS);

    wr(A_MODE, 16'h20B0);
    expect_v("mode_aa_speed", 32'h20);   check(AA_SPEED);
    expect_v("mode_aa_dis", 32'h0);      check(AA_DISABLE);
    wr(A_TH, 16'h0000);
    wr(A_TL, 16'h0003);
    expect_v("tl_load", 32'h3);          check(cnt());
    pix(3);
    expect_v("cnt_at_zero", 32'h0);      check(cnt());
    expect_v("no_flag_yet", 32'h0);      check(IRQ_FLAGS);
    pix(1);
    expect_v("timer_flag1", 32'h2);      check(IRQ_FLAGS);
    expect_v("reload_zero1", 32'h3);     check(cnt());

    wr(A_ACK, 16'h0002);
    expect_v("ack_timer", 32'h0);        check(IRQ_FLAGS);
    pix(3);
    expect_v("no_flag_r2", 32'h0);       check(IRQ_FLAGS);
    pix(1);
    expect_v("timer_flag2", 32'h2);      check(IRQ_FLAGS);
    expect_v("reload_zero2", 32'h3);     check(cnt());

    wr(A_ACK, 16'h0002);
    wr(A_MODE, 16'h0010);
    pix(3);
    expect_v("wrap_pre", 32'h0);         check(cnt());
    pix(1);
    expect_v("wrap_flag", 32'h2);        check(IRQ_FLAGS);
    expect_v("wrap_cnt", 32'hFFFF_FFFF); check(cnt());

    wr(A_MODE, 16'h0850);
    expect_v("aa_speed_08", 32'h08);     check(AA_SPEED);
    wr(A_TH, 16'h0000);
    wr(A_TL, 16'h0100);
    expect_v("tl_no_load", 32'hFFFF_FFFF); check(cnt());
    wr(A_ACK, 16'h0007);
    expect_v("ack_all", 32'h0);          check(IRQ_FLAGS);
    VBLANK_START = 1'b1;
    PIXEL_CE = 1'b1;
    tick();
    expect_v("vbl_load", 32'h100);       check(cnt());
    expect_v("vbl_flag", 32'h1);         check(IRQ_FLAGS);

    wr(A_MODE, 16'h00B0);
    wr(A_TL, 16'h0000);
    expect_v("tl_load_zero", 32'h0);     check(cnt());
    PIXEL_CE = 1'b1;
    wr(A_ACK, 16'h0002);
    expect_v("set_beats_ack", 32'h3);    check(IRQ_FLAGS);

    wr(A_ACK, 16'h0003);
    expect_v("ack_3", 32'h0);            check(IRQ_FLAGS);
    PIXEL_CE = 1'b1;
    wr(A_TL, 16'h0005);
    expect_v("tl_over_zero_flag", 32'h2); check(IRQ_FLAGS);
    expect_v("tl_over_zero_cnt", 32'h5);  check(cnt());
    VBLANK_START = 1'b1;
    wr(A_ACK, 16'h0004);
    expect_v("vbl_beats_ack", 32'h3);    check(IRQ_FLAGS);
    expect_v("vbl_no_load", 32'h5);      check(cnt());

    wr(A_MODE, 16'h0088);
    expect_v("aa_dis_set", 32'h1);       check(AA_DISABLE);
    wr(A_ACK, 16'h0007);
    pix(5);
    expect_v("masked_pre", 32'h0);       check(cnt());
    pix(1);
    expect_v("masked_flag", 32'h0);      check(IRQ_FLAGS);
    expect_v("masked_reload", 32'h5);    check(cnt());

    RASTER_LINE = 9'h1F8; PAL_MODE = 1'b1; AA_COUNT = 3'd5;
    #1;
    expect_v("rd_data1", 32'hFC0D);      check(RD_DATA);
    RASTER_LINE = 9'h001; PAL_MODE = 1'b0; AA_COUNT = 3'd2;
    #1;
    expect_v("rd_data2", 32'h0082);      check(RD_DATA);

    wr(A_MODE, 16'h55B8);
    pix(2);
    PIXEL_CE = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    expect_v("mid_rst_speed", 32'h0);    check(AA_SPEED);
    expect_v("mid_rst_dis", 32'h0);      check(AA_DISABLE);
    expect_v("mid_rst_flags", 32'h4);    check(IRQ_FLAGS);
    expect_v("mid_rst_cnt", 32'h0);      check(cnt());
    #1;
    RESET = 1'b0;
    tick();
    expect_v("post_rst_wrap", 32'hFFFF_FFFF); check(cnt());
    expect_v("post_rst_flags", 32'h4);   check(IRQ_FLAGS);

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
